// File: rtl/mem_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_resp_pkg
// Purpose  : Shared types and constants for the main memory responder.
// Revision : 1.0 - initial release
// ============================================================================
package mem_resp_pkg;

  // Width of the access-latency down-counter; covers LATENCY up to 255.
  localparam int LAT_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    GAP  = 2'd3
  } mem_resp_state_e;

endpackage : mem_resp_pkg
`default_nettype wire

// File: rtl/mem_resp_sram.sv
`default_nettype none
// ============================================================================
// Module   : mem_resp_sram
// Purpose  : Single-port synchronous word array with registered read data.
//            Contents and read register are deliberately not reset.
// Revision : 1.0 - initial release
// ============================================================================
module mem_resp_sram
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem_array [2**DEPTH_LOG2];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  // Read register only updates on a read so that a write leaves it untouched.
  always_comb begin
    rdata_d = rdata_q;
    if (re && !we) begin
      rdata_d = mem_array[idx];
    end
  end

  // Array write port and read-data register.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_array[idx] <= wdata;
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule : mem_resp_sram
`default_nettype wire

// File: rtl/main_memory_responder.sv
`default_nettype none
// ============================================================================
// Module   : main_memory_responder
// Purpose  : Memory-side target for the cache controller's mem_* interface.
//            One request at a time, fixed access latency, one-cycle
//            mem_ready pulse, sticky out-of-range flag, saturating counters.
// Revision : 1.0 - initial release
// ============================================================================
module main_memory_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              mem_busy,
  output logic              oob_err,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count
);

  mem_resp_state_e       state_q, state_d;
  logic [LAT_CNT_W-1:0]  cnt_q, cnt_d;
  logic                  write_q, write_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  oob_q, oob_d;
  logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]      wr_cnt_q, wr_cnt_d;
  logic                  ready_q, ready_d;
  logic                  rdv_q, rdv_d;   // a read has completed since reset

  logic                  accept;
  logic                  sram_we;
  logic                  sram_re;
  logic [DATA_W-1:0]     sram_rdata;

  // Next-state, request latch, access strobes, error flag and counters.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    write_d  = write_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    oob_d    = oob_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    rdv_d    = rdv_q;
    accept   = 1'b0;
    sram_we  = 1'b0;
    sram_re  = 1'b0;

    case (state_q)
      IDLE: begin
        accept = mem_req;
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - LAT_CNT_W'(1);
        end else begin
          state_d = RESP;
          sram_we = write_q;
          sram_re = !write_q;
          if (write_q) begin
            if (wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + CNT_W'(1);
          end else begin
            rdv_d = 1'b1;
            if (rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + CNT_W'(1);
          end
        end
      end
      RESP: begin
        state_d = GAP;
      end
      GAP: begin
        // The edge leaving GAP is the earliest point a new request may be
        // taken; a request still present here starts the next access.
        state_d = IDLE;
        accept  = mem_req;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept) begin
      state_d = WAIT;
      cnt_d   = LAT_CNT_W'(LATENCY - 1);
      write_d = mem_write;
      idx_d   = mem_addr[DEPTH_LOG2-1:0];
      wdata_d = mem_wdata;
      if (|mem_addr[ADDR_W-1:DEPTH_LOG2]) begin
        oob_d = 1'b1;
      end
    end

    ready_d = (state_d == RESP);
  end

  // State and control registers; reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      write_q  <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      oob_q    <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      ready_q  <= 1'b0;
      rdv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      write_q  <= write_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      oob_q    <= oob_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      ready_q  <= ready_d;
      rdv_q    <= rdv_d;
    end
  end

  mem_resp_sram #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_W     (DATA_W)
  ) u_sram (
    .clk   (clk),
    .we    (sram_we),
    .re    (sram_re),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (sram_rdata)
  );

  // The unreset read register is masked until the first read after reset.
  assign mem_rdata = rdv_q ? sram_rdata : '0;
  assign mem_ready = ready_q;
  assign mem_busy  = (state_q != IDLE);
  assign oob_err   = oob_q;
  assign rd_count  = rd_cnt_q;
  assign wr_count  = wr_cnt_q;

endmodule : main_memory_responder
`default_nettype wire
